alarm_scheduler: RTL

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alarm_scheduler.sv
// Four-slot daily alarm with ring timeout, bounded snooze and midnight-wrapping snooze target.
// Slot matches are evaluated only on minute rollover; the lowest matching slot index wins.
module alarm_scheduler #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       min_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic       cfg_we,
    input  logic [1:0] cfg_slot,
    input  logic       cfg_en,
    input  logic [4:0] cfg_hour,
    input  logic [5:0] cfg_min,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       ring,
    output logic [1:0] ring_slot,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    localparam int CNT_W = (RING_SECS < 2) ? 1 : $clog2(RING_SECS + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t            state_q, state_d;
    logic              slot_en_q   [4];
    logic [4:0]        slot_hour_q [4];
    logic [5:0]        slot_min_q  [4];
    logic [CNT_W-1:0]  sec_cnt_q;
    logic [10:0]       target_q, target_d;
    logic [1:0]        ring_slot_q, ring_slot_d;
    logic [1:0]        snooze_cnt_q, snooze_cnt_d;

    logic              match_any;
    logic [1:0]        winner;
    logic [10:0]       now_min;
    logic              target_hit;
    logic              abort;
    logic              timeout;

    function automatic logic [10:0] minute_of_day(input logic [4:0] h, input logic [5:0] m);
        return ({6'd0, h} * 11'd60) + {5'd0, m};
    endfunction

    // Snooze target as minute-of-day, folded back past midnight.
    function automatic logic [10:0] snooze_target(input logic [10:0] t);
        logic [11:0] s;
        s = {1'b0, t} + 12'(SNOOZE_MIN);
        if (s >= 12'd1440)
            s = s - 12'd1440;
        return s[10:0];
    endfunction

    assign now_min    = minute_of_day(cur_hour, cur_min);
    assign target_hit = (now_min == target_q);
    assign abort      = cfg_we && (cfg_slot == ring_slot_q);
    assign timeout    = sec_tick && (sec_cnt_q == CNT_W'(RING_SECS - 1));

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        match_any = 1'b0;
        winner    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_en_q[i] && slot_hour_q[i] == cur_hour && slot_min_q[i] == cur_min &&
                slot_hour_q[i] < 5'd24 && slot_min_q[i] < 6'd60) begin
                match_any = 1'b1;
                winner    = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_slot_d  = ring_slot_q;
        snooze_cnt_d = snooze_cnt_q;
        target_d     = target_q;
        case (state_q)
            IDLE: begin
                if (min_tick && match_any) begin
                    state_d      = RING;
                    ring_slot_d  = winner;
                    snooze_cnt_d = 2'd0;
                end
            end
            RING: begin
                if (dismiss_btn || abort || timeout) begin
                    state_d      = IDLE;
                    snooze_cnt_d = 2'd0;
                end else if (snooze_btn && snooze_cnt_q < 2'(MAX_SNOOZE)) begin
                    state_d      = SNOOZE;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                    target_d     = snooze_target(now_min);
                end
            end
            SNOOZE: begin
                if (dismiss_btn || abort) begin
                    state_d      = IDLE;
                    snooze_cnt_d = 2'd0;
                end else if (min_tick && target_hit) begin
                    state_d = RING;
                end else if (min_tick && match_any) begin
                    state_d      = RING;
                    ring_slot_d  = winner;
                    snooze_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d      = IDLE;
                snooze_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ring_slot_q  <= 2'd0;
            snooze_cnt_q <= 2'd0;
            target_q     <= 11'd0;
            sec_cnt_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_en_q[i]   <= 1'b0;
                slot_hour_q[i] <= 5'd0;
                slot_min_q[i]  <= 6'd0;
            end
        end else begin
            state_q      <= state_d;
            ring_slot_q  <= ring_slot_d;
            snooze_cnt_q <= snooze_cnt_d;
            target_q     <= target_d;
            // Counter idles at zero outside RING, so every entry starts a fresh ring period.
            if (state_q != RING)
                sec_cnt_q <= '0;
            else if (sec_tick)
                sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            if (cfg_we) begin
                slot_en_q[cfg_slot]   <= cfg_en;
                slot_hour_q[cfg_slot] <= cfg_hour;
                slot_min_q[cfg_slot]  <= cfg_min;
            end
        end
    end

    assign ring       = (state_q == RING);
    assign snoozing   = (state_q == SNOOZE);
    assign ring_slot  = ring_slot_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule
